// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// instruction word width and the default load address.
package imem_loader_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RELEASE,
        ST_CSUM
    } state_t;

    // Byte address of a word slot: base plus four bytes per word index.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                    input logic [WORD_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte packer: shifts accepted bytes into a 32-bit word and flags
// the byte that completes a group. The group length is last_idx+1, so the
// same block assembles both the 2-byte header and the 4-byte data words.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    input  logic [1:0]        last_idx,
    output logic [WORD_W-1:0] word,
    output logic              word_ok
);

    logic [1:0] count;

    // Shift each accepted byte in at the bottom so the first byte ends up on top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            word  <= {word[WORD_W-9:0], byte_in};
            count <= (count == last_idx) ? 2'd0 : count + 2'd1;
        end
    end

    assign word_ok = shift_en && (count == last_idx);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream, packs it
// into 32-bit words written from BASE_ADDR upward, then pulses int_out so the
// PC block starts fetching at entry_point.
// Optional trailing XOR checksum byte is enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = 256,
    parameter int          LEN_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        int_out,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic        err_csum,
`endif
    output logic [31:0] entry_point,
    output logic        err_len
);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               shift_en;
    logic [1:0]         last_idx;
    logic [WORD_W-1:0]  packed_word;
    logic               word_ok;
    logic [LEN_W-1:0]   hdr_len;
    logic               len_bad;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   word_idx;
    logic               last_word;
    logic               set_err_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
    logic               set_err_csum;
`endif

    // Handshake and status outputs depend on the state alone.
    assign byte_ready  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign accept      = byte_valid && byte_ready;
    assign shift_en    = accept && ((state == ST_HDR) || (state == ST_DATA));
    assign last_idx    = (state == ST_HDR) ? 2'd1 : 2'd3;
    assign busy        = (state != ST_IDLE);
    assign wr_en       = (state == ST_WRITE);
    assign int_out     = (state == ST_RELEASE);
    assign entry_point = BASE_ADDR;
    assign wr_addr     = wr_en ? word_addr(BASE_ADDR, 32'(word_idx)) : 32'd0;
    assign wr_data     = wr_en ? packed_word : 32'd0;

    // The second header byte is still on the bus when the length is judged.
    assign hdr_len   = LEN_W'({packed_word[7:0], byte_data});
    assign len_bad   = (hdr_len == '0) || (hdr_len > LEN_W'(MAX_WORDS));
    assign last_word = ((word_idx + LEN_W'(1)) == len_reg);

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_IDLE),
        .shift_en (shift_en),
        .byte_in  (byte_data),
        .last_idx (last_idx),
        .word     (packed_word),
        .word_ok  (word_ok)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and error-flag requests.
    always_comb begin
        state_next  = state;
        set_err_len = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        set_err_csum = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_HDR;
            end
            ST_HDR: begin
                if (word_ok) begin
                    if (len_bad) begin
                        set_err_len = 1'b1;
                        state_next  = ST_IDLE;
                    end else begin
                        state_next  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_ok) state_next = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_next = last_word ? ST_CSUM : ST_DATA;
`else
                state_next = last_word ? ST_RELEASE : ST_DATA;
`endif
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (byte_data == csum) begin
                        state_next = ST_RELEASE;
                    end else begin
                        set_err_csum = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Length, word index, sticky status flags and the running checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg  <= '0;
            word_idx <= '0;
            done     <= 1'b0;
            err_len  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
            err_csum <= 1'b0;
`endif
        end else begin
            if ((state == ST_IDLE) && start) begin
                done     <= 1'b0;
                err_len  <= 1'b0;
                word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
                err_csum <= 1'b0;
`endif
            end
            if ((state == ST_HDR) && word_ok) len_reg <= hdr_len;
            if (state == ST_WRITE) word_idx <= word_idx + LEN_W'(1);
            if (state == ST_RELEASE) done <= 1'b1;
            if (set_err_len) err_len <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (shift_en) csum <= csum ^ byte_data;
            if (set_err_csum) err_csum <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-fetch path: takes a byte stream from a host, packs it into 32-bit words and writes them into instruction memory from BASE_ADDR upward.
- On completion, issues the one-cycle INT pulse plus entry point that the PC block consumes to start fetching.
- Sits between the host/boot link and the instruction-memory write port; the fetch stage remains the reader.

Parameters:
- BASE_ADDR, 128, byte address of the first word written; also driven on entry_point.
- MAX_WORDS, 256, largest accepted program length in words.
- LEN_W, 16, width of the length header field (bits).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a load when in IDLE, ignored otherwise.
- byte_valid  in  1  host byte available.
- byte_data  in  8  host byte.
- byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready).
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  32  byte address of the word being written.
- wr_data  out  32  packed instruction word.
- busy  out  1  load in progress.
- done  out  1  sticky; set after a successful load, cleared by start.
- int_out  out  1  one-cycle pulse to the PC block.
- entry_point  out  32  constant BASE_ADDR.
- err_len  out  1  sticky; header length 0 or > MAX_WORDS.

Behaviour:
- Reset: all outputs 0 except entry_point = BASE_ADDR; state IDLE; counters 0.
- States: IDLE -> HDR (2 bytes) -> DATA (4 bytes per word) -> WRITE (1 cycle) -> DATA or RELEASE -> IDLE.
- IDLE: byte_ready = 0. On start, clear done/err_len, go to HDR.
- HDR:
  - byte_ready = 1.
  - First byte is len[15:8], second is len[7:0] (big-endian).
  - After byte 2: if len == 0 or len > MAX_WORDS, set err_len and return to IDLE with no writes and no int_out.
  - Otherwise go to DATA.
- DATA:
  - byte_ready = 1.
  - Bytes are packed big-endian: first byte goes to [31:24].
  - After the 4th byte, go to WRITE.
- WRITE:
  - byte_ready = 0; wr_en = 1 for exactly one cycle.
  - wr_addr = BASE_ADDR + 4*word_idx; wr_data = assembled word.
  - word_idx increments. If word_idx+1 == len go to RELEASE, else DATA.
- RELEASE: int_out = 1 for one cycle; set done; go to IDLE.
- busy = 1 in every state except IDLE.
- Latency: first wr_en one cycle after the 4th byte of word 0 is accepted. int_out one cycle after the last wr_en.
- byte_valid = 0 stalls indefinitely; partial words are held.
- start asserted while busy is ignored.
- reset mid-load: immediate abort. Words already written stay in memory; no int_out.
- Address arithmetic: 32-bit unsigned, no wrap check (MAX_WORDS bounds it).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last data word, one extra byte is expected (state CSUM, byte_ready = 1).
  - It must equal the XOR of all header and data bytes.
  - On match, go to RELEASE.
  - On mismatch, set sticky err_csum (extra 1-bit output port), skip int_out, leave done = 0, return to IDLE.
- When undefined: no CSUM state and no err_csum port; WRITE of the last word goes straight to RELEASE.

Decomposition:
- Shared package (or include file):
  - state encoding constants (IDLE, HDR, DATA, WRITE, RELEASE, CSUM);
  - default BASE_ADDR = 128;
  - instruction word width 32.
- One sub-module is natural: byte_packer.
  - Shift register plus 2-bit byte counter.
  - Emits word_ok after 4 accepted bytes; reusable for the 2-byte header with a count limit.

Test Plan:
- Header 00 02, words 20090005 and 8C0A0000 -> wr_en twice: (128, 0x20090005), (132, 0x8C0A0000); int_out one pulse one cycle after the second write; done = 1.
- Header 00 00 -> err_len = 1; no wr_en; no int_out; busy back to 0 after 2 bytes.
- Header 01 01 (257 > MAX_WORDS) -> err_len = 1, no writes.
- 1-word load with byte_valid dropped for 5 cycles after byte 2 of the word -> word 0x12345678 still written once at address 128.
- reset asserted after 3 data bytes -> all outputs 0 at once (entry_point = 128); a new start then loads correctly from address 128.
- With IMEM_LOADER_CHECKSUM_EN: 1-word load of 0x01020304 with header 00 01 -> checksum byte 0x05 gives int_out; checksum byte 0x00 gives err_csum = 1 and no int_out.
